// File: rtl/spi_target.sv
// SPI target (CPHA=0, CPOL=POLARITY) with a 4-word CPU register file.
// Define SPI_TARGET_FIFO_EN to replace the single RX holding register with a 4-entry FIFO.
module spi_target #(
  parameter bit POLARITY = 1'b1
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        select,
  input  logic [3:0]  we,
  input  logic        rd,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        spi_sck,
  input  logic        spi_ss_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        interrupt
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t      state, state_nxt;
  logic        sck_p0, sck_p1, sck_p2;
  logic        ss_p0, ss_p1, ss_p2, ss_armed;
  logic        mosi_p0, mosi_p1;
  logic        lead_edge, trail_edge, ss_fall, ss_rise, ss_active;
  logic        shifting, start, leaving, lead, trail, reload;
  logic [2:0]  bit_cnt;
  logic [7:0]  rx_shift, tx_shift, tx_hold, rx_byte;
  logic        tx_empty, rx_overrun, tx_underrun, frame_end;
  logic [2:0]  ctrl;
  logic        wr_data, wr_stat, wr_ctrl, pop_req, rx_push;
  logic        pop, push, rx_full_after_pop, rx_valid;
  logic [7:0]  rx_data;
  logic [2:0]  rx_level;
  logic        unused_bits;

  assign unused_bits = ^{we[3:1], wdata[31:8]};

  // Stage p0..p2: pin synchronisers; SS flops reset low so a held-low SS
  // never looks like a falling edge until it has been seen high once.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      sck_p0   <= POLARITY;
      sck_p1   <= POLARITY;
      sck_p2   <= POLARITY;
      ss_p0    <= 1'b0;
      ss_p1    <= 1'b0;
      ss_p2    <= 1'b0;
      ss_armed <= 1'b0;
      mosi_p0  <= 1'b0;
      mosi_p1  <= 1'b0;
    end else begin
      sck_p0   <= spi_sck;
      sck_p1   <= sck_p0;
      sck_p2   <= sck_p1;
      ss_p0    <= spi_ss_n;
      ss_p1    <= ss_p0;
      ss_p2    <= ss_p1;
      ss_armed <= ss_armed | ss_p1;
      mosi_p0  <= spi_mosi;
      mosi_p1  <= mosi_p0;
    end
  end

  assign lead_edge  = POLARITY ? (~sck_p1 & sck_p2) : (sck_p1 & ~sck_p2);
  assign trail_edge = POLARITY ? (sck_p1 & ~sck_p2) : (~sck_p1 & sck_p2);
  assign ss_fall    = ss_armed & ~ss_p1 & ss_p2;
  assign ss_rise    = ss_p1 & ~ss_p2;
  assign ss_active  = ss_armed & ~ss_p1;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ss_fall && ctrl[0]) state_nxt = SHIFT;
      SHIFT:   if (ss_rise || !ctrl[0]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shifting    = (state == SHIFT);
    start       = (state == IDLE) & ss_fall & ctrl[0];
    leaving     = shifting & (ss_rise | ~ctrl[0]);
    lead        = shifting & ~leaving & lead_edge;
    trail       = shifting & ~leaving & trail_edge;
    spi_miso_oe = ctrl[0] & shifting;
  end

  assign wr_data = select & we[0] & (addr == 2'd0);
  assign wr_stat = select & we[0] & (addr == 2'd1);
  assign wr_ctrl = select & we[0] & (addr == 2'd2);
  assign pop_req = select & rd & (addr == 2'd0);
  assign rx_byte = {rx_shift[6:0], mosi_p1};
  assign rx_push = lead & (bit_cnt == 3'd7);
  assign reload  = start | (trail & (bit_cnt == 3'd0));

  // Shifters, TX hold and sticky flags; a CPU write lands after any reload in the same cycle.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      bit_cnt     <= 3'd0;
      rx_shift    <= 8'hFF;
      tx_shift    <= 8'hFF;
      tx_hold     <= 8'h00;
      tx_empty    <= 1'b1;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
      frame_end   <= 1'b0;
      ctrl        <= 3'd0;
    end else begin
      if (start || leaving) begin
        bit_cnt <= 3'd0;
      end else if (lead) begin
        bit_cnt  <= bit_cnt + 3'd1;
        rx_shift <= rx_byte;
      end
      if (reload)     tx_shift <= tx_empty ? 8'hFF : tx_hold;
      else if (trail) tx_shift <= {tx_shift[6:0], 1'b1};
      if (reload) tx_empty <= 1'b1;
      if (wr_data) begin
        tx_hold  <= wdata[7:0];
        tx_empty <= 1'b0;
      end
      if (wr_stat && wdata[2]) rx_overrun  <= 1'b0;
      if (wr_stat && wdata[3]) tx_underrun <= 1'b0;
      if (wr_stat && wdata[5]) frame_end   <= 1'b0;
      if (rx_push && rx_full_after_pop) rx_overrun  <= 1'b1;
      if (reload && tx_empty)           tx_underrun <= 1'b1;
      if (shifting && ss_rise)          frame_end   <= 1'b1;
      if (wr_ctrl) ctrl <= wdata[2:0];
    end
  end

`ifdef SPI_TARGET_FIFO_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] rd_ptr, wr_ptr;
  logic [2:0] rx_count;

  assign pop               = pop_req & (rx_count != 3'd0);
  assign rx_full_after_pop = (rx_count == 3'd4) & ~pop;
  assign push              = rx_push & ~rx_full_after_pop;
  assign rx_valid          = (rx_count != 3'd0);
  assign rx_data           = rx_valid ? fifo_mem[rd_ptr] : 8'h00;
  assign rx_level          = rx_count;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= rx_byte;
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rd_ptr   <= 2'd0;
      wr_ptr   <= 2'd0;
      rx_count <= 3'd0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      if (push) wr_ptr <= wr_ptr + 2'd1;
      rx_count <= rx_count + {2'b0, push} - {2'b0, pop};
    end
  end
`else
  logic [7:0] rx_hold;
  logic       rx_full;

  assign pop               = pop_req & rx_full;
  assign rx_full_after_pop = rx_full & ~pop;
  assign push              = rx_push & ~rx_full_after_pop;
  assign rx_valid          = rx_full;
  assign rx_data           = rx_hold;
  assign rx_level          = 3'd0;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_hold <= 8'h00;
      rx_full <= 1'b0;
    end else if (push) begin
      rx_hold <= rx_byte;
      rx_full <= 1'b1;
    end else if (pop) begin
      rx_full <= 1'b0;
    end
  end
`endif

  always_comb begin
    rdata = '0;
    case (addr)
      2'd0:    rdata[7:0] = rx_data;
      2'd1:    rdata[8:0] = {rx_level, frame_end, ss_active, tx_underrun,
                             rx_overrun, tx_empty, rx_valid};
      2'd2:    rdata[2:0] = ctrl;
      default: rdata = '0;
    endcase
  end

  assign spi_miso  = tx_shift[7];
  assign interrupt = (rx_valid & ctrl[1]) | (frame_end & ctrl[2]);

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: a POLARITY=1 and a POLARITY=0 instance share one SPI host
// (the second sees the inverted clock) and are checked against a transaction-level model.
module tb_spi_target;

  logic        clk = 1'b0;
  logic        resetq, select, rd, sck, ss_n, mosi, sck_b;
  logic [3:0]  we;
  logic [1:0]  addr;
  logic [31:0] wdata, rdata0, rdata1;
  logic        miso0, oe0, irq0, miso1, oe1, irq1;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;
  assign sck_b = ~sck;

  spi_target u_dut0 (
    .clk(clk), .resetq(resetq), .select(select), .we(we), .rd(rd), .addr(addr),
    .wdata(wdata), .rdata(rdata0), .spi_sck(sck), .spi_ss_n(ss_n), .spi_mosi(mosi),
    .spi_miso(miso0), .spi_miso_oe(oe0), .interrupt(irq0)
  );

  spi_target #(.POLARITY(1'b0)) u_dut1 (
    .clk(clk), .resetq(resetq), .select(select), .we(we), .rd(rd), .addr(addr),
    .wdata(wdata), .rdata(rdata1), .spi_sck(sck_b), .spi_ss_n(ss_n), .spi_mosi(mosi),
    .spi_miso(miso1), .spi_miso_oe(oe1), .interrupt(irq1)
  );

`ifdef SPI_TARGET_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  // Transaction-level reference model
  logic [7:0] m_q[$];
  logic [7:0] m_hold, m_shift;
  logic       m_empty, m_ro, m_uo, m_fe, m_active;
  logic [2:0] m_ctrl;

  function automatic void m_reset();
    m_q.delete();
    m_hold = 8'h00; m_shift = 8'hFF; m_empty = 1'b1;
    m_ro = 1'b0; m_uo = 1'b0; m_fe = 1'b0; m_active = 1'b0; m_ctrl = 3'd0;
  endfunction

  function automatic void m_reload();
    if (m_empty) begin
      m_shift = 8'hFF;
      m_uo    = 1'b1;
    end else begin
      m_shift = m_hold;
    end
    m_empty = 1'b1;
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s = '0;
    s[0] = (m_q.size() != 0);
    s[1] = m_empty;
    s[2] = m_ro;
    s[3] = m_uo;
    s[5] = m_fe;
`ifdef SPI_TARGET_FIFO_EN
    s[8:6] = 3'(m_q.size());
`endif
    return s;
  endfunction

  function automatic logic m_irq();
    return ((m_q.size() != 0) & m_ctrl[1]) | (m_fe & m_ctrl[2]);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    select = 1'b1; we = 4'h1; addr = a; wdata = d;
    @(negedge clk);
    select = 1'b0; we = 4'h0; wdata = '0;
    case (a)
      2'd0: begin m_hold = d[7:0]; m_empty = 1'b0; end
      2'd1: begin
        if (d[2]) m_ro = 1'b0;
        if (d[3]) m_uo = 1'b0;
        if (d[5]) m_fe = 1'b0;
      end
      2'd2: m_ctrl = d[2:0];
      default: ;
    endcase
  endtask

  task automatic cpu_rd(input logic [1:0] a, input logic pop,
                        output logic [31:0] d0, output logic [31:0] d1);
    @(negedge clk);
    select = 1'b1; addr = a; rd = pop;
    #1;
    d0 = rdata0; d1 = rdata1;
    @(negedge clk);
    select = 1'b0; rd = 1'b0;
    if (pop && a == 2'd0 && m_q.size() != 0) void'(m_q.pop_front());
  endtask

  task automatic check_status(input string tag);
    logic [31:0] d0, d1;
    cpu_rd(2'd1, 1'b0, d0, d1);
    check({tag, "_stat0"}, d0, m_status());
    check({tag, "_stat1"}, d1, m_status());
    check({tag, "_irq0"}, {31'b0, irq0}, {31'b0, m_irq()});
  endtask

  task automatic check_pop(input string tag);
    logic [31:0] d0, d1;
    logic [7:0]  exp;
    exp = m_q[0];
    cpu_rd(2'd0, 1'b1, d0, d1);
    check({tag, "_data0"}, d0, {24'b0, exp});
    check({tag, "_data1"}, d1, {24'b0, exp});
  endtask

  task automatic half_bit();
    repeat (5) @(negedge clk);
  endtask

  task automatic host_ss_fall();
    ss_n = 1'b0;
    repeat (8) @(negedge clk);
    if (m_ctrl[0]) begin
      m_active = 1'b1;
      m_reload();
    end
  endtask

  task automatic host_ss_rise();
    repeat (8) @(negedge clk);
    ss_n = 1'b1;
    repeat (8) @(negedge clk);
    if (m_active) m_fe = 1'b1;
    m_active = 1'b0;
  endtask

  task automatic xfer(input string tag, input logic [7:0] tx, input int nbits);
    logic [7:0] r0, r1;
    r0 = '0; r1 = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      half_bit();
      sck = 1'b0;
      r0 = {r0[6:0], miso0};
      r1 = {r1[6:0], miso1};
      half_bit();
      sck = 1'b1;
    end
    if (nbits == 8 && m_active) begin
      check({tag, "_miso0"}, {24'b0, r0}, {24'b0, m_shift});
      check({tag, "_miso1"}, {24'b0, r1}, {24'b0, m_shift});
      if (m_q.size() < CAP) m_q.push_back(tx);
      else                  m_ro = 1'b1;
      m_reload();
    end
  endtask

  task automatic clear_flags();
    cpu_wr(2'd1, 32'h2C);
  endtask

  initial begin
    logic [31:0] d0, d1;
    int          nb;
    resetq = 1'b0; select = 1'b0; rd = 1'b0; we = 4'h0; addr = 2'd0; wdata = '0;
    sck = 1'b1; ss_n = 1'b1; mosi = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    // Reset state
    check("rst_oe0", {31'b0, oe0}, 32'd0);
    check("rst_oe1", {31'b0, oe1}, 32'd0);
    check("rst_irq", {31'b0, irq0}, 32'd0);
    check("rst_miso", {31'b0, miso0}, 32'd1);
    check_status("rst");
    resetq = 1'b1;
    repeat (4) @(negedge clk);
    cpu_rd(2'd2, 1'b0, d0, d1);
    check("rst_ctrl", d0, 32'd0);
    cpu_rd(2'd3, 1'b0, d0, d1);
    check("reg3", d0, 32'd0);

    // Basic exchange: hold 0xA5, host sends 0x3C
    cpu_wr(2'd2, 32'h1);
    cpu_wr(2'd3, 32'hFFFF_FFFF);
    cpu_rd(2'd3, 1'b0, d0, d1);
    check("reg3_wr", d0, 32'd0);
    cpu_wr(2'd0, 32'hA5);
    host_ss_fall();
    check("oe_shift", {31'b0, oe0}, 32'd1);
    xfer("basic", 8'h3C, 8);
    host_ss_rise();
    check("oe_idle", {31'b0, oe0}, 32'd0);
    check_status("basic");
    check_pop("basic");
    check_status("basic_pop");
    clear_flags();
    check_status("basic_clr");

    // Underrun with TX empty, then clear with 0x08
    host_ss_fall();
    xfer("under", 8'h55, 8);
    host_ss_rise();
    check_status("under");
    cpu_wr(2'd1, 32'h08);
    check_status("under_clr");
    check_pop("under");
    clear_flags();

    // Two bytes without a pop: overrun (single register) or two FIFO entries
    cpu_wr(2'd0, 32'h96);
    host_ss_fall();
    xfer("two_a", 8'h11, 8);
    xfer("two_b", 8'h22, 8);
    host_ss_rise();
    check_status("two");
    while (m_q.size() != 0) check_pop("two");
    check_status("two_empty");
    clear_flags();

    // Aborted frame after 5 bits with frame interrupt
    cpu_wr(2'd2, 32'h5);
    cpu_rd(2'd2, 1'b0, d0, d1);
    check("ctrl_rb", d0, 32'h5);
    host_ss_fall();
    xfer("abort", 8'hF0, 5);
    host_ss_rise();
    check_status("abort");
    check("abort_irq", {31'b0, irq0}, 32'd1);
    clear_flags();
    check_status("abort_clr");

    // RX interrupt
    cpu_wr(2'd2, 32'h3);
    cpu_wr(2'd0, 32'h42);
    host_ss_fall();
    xfer("rxirq", 8'hE7, 8);
    host_ss_rise();
    check_status("rxirq");
    check_pop("rxirq");
    check_status("rxirq_pop");
    clear_flags();

    // Randomised frames
    cpu_wr(2'd2, 32'h1);
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) == 1) cpu_wr(2'd0, {24'b0, 8'($urandom)});
      nb = $urandom_range(1, 3);
      host_ss_fall();
      for (int b = 0; b < nb; b++) xfer("rand", 8'($urandom), 8);
      host_ss_rise();
      check_status("rand");
      while (m_q.size() != 0) check_pop("rand");
      clear_flags();
    end

    // POLARITY=0 instance receives 0x81
    cpu_wr(2'd0, 32'h81);
    host_ss_fall();
    xfer("pol0", 8'h81, 8);
    host_ss_rise();
    cpu_rd(2'd0, 1'b1, d0, d1);
    check("pol0_data1", d1, 32'h81);
    check("pol0_data0", d0, 32'h81);
    void'(m_q.pop_front());
    clear_flags();

    // Reset pulsed mid-byte, then SS held low must not start a frame
    cpu_wr(2'd0, 32'h77);
    host_ss_fall();
    xfer("mid", 8'hAA, 5);
    @(negedge clk);
    resetq = 1'b0;
    #2;
    m_reset();
    check("mid_oe0", {31'b0, oe0}, 32'd0);
    check("mid_oe1", {31'b0, oe1}, 32'd0);
    check("mid_irq", {31'b0, irq0}, 32'd0);
    check("mid_miso", {31'b0, miso0}, 32'd1);
    check_status("mid_rst");
    cpu_rd(2'd2, 1'b0, d0, d1);
    check("mid_ctrl", d0, 32'd0);
    cpu_rd(2'd0, 1'b0, d0, d1);
    check("mid_data", d0, 32'd0);
    resetq = 1'b1;
    repeat (4) @(negedge clk);
    cpu_wr(2'd2, 32'h1);
    repeat (10) @(negedge clk);
    check("mid_noshift", {31'b0, oe0}, 32'd0);
    check_status("mid_held");
    cpu_wr(2'd0, 32'h5A);
    ss_n = 1'b1;
    repeat (8) @(negedge clk);
    host_ss_fall();
    xfer("mid_next", 8'hC3, 8);
    host_ss_rise();
    check_status("mid_next");
    check_pop("mid_next");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 SHALL have parameter POLARITY, default 1: SCK idle level (CPOL); CPHA fixed at 0.
REQ-002 SHALL have port clk  input  1  system clock; all logic in this single domain.
REQ-003 SHALL have port resetq  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port select  input  1  CPU bus select.
REQ-005 SHALL have port we  input  4  CPU byte write mask.
REQ-006 SHALL have port rd  input  1  CPU read strobe.
REQ-007 SHALL have port addr  input  2  word register index.
REQ-008 SHALL have port wdata  input  32  CPU write data.
REQ-009 SHALL have port rdata  output  32  register read data, combinational from addr.
REQ-010 SHALL have port spi_sck  input  1  host SPI clock, asynchronous.
REQ-011 SHALL have port spi_ss_n  input  1  host chip select, active-low, asynchronous.
REQ-012 SHALL have port spi_mosi  input  1  host data in.
REQ-013 SHALL have port spi_miso  output  1  data to host.
REQ-014 SHALL have port spi_miso_oe  output  1  MISO pad output enable.
REQ-015 SHALL have port interrupt  output  1  level interrupt to CPU.

Function
REQ-016 SHALL pass spi_sck, spi_ss_n and spi_mosi through 2-flop synchronisers and derive edges in clk; supported SCK frequency is at most clk/8.
REQ-017 SHALL map registers: 0 DATA (read = {24'b0, rx byte}, read with rd pops; write with we[0] loads TX hold), 1 STATUS, 2 CONTROL, 3 reads 0, writes ignored.
REQ-018 SHALL use STATUS bits: 0 rx_valid, 1 tx_empty, 2 rx_overrun, 3 tx_underrun, 4 ss_active, 5 frame_end; writing 1 to bits 2, 3 and 5 clears them.
REQ-019 SHALL use CONTROL bits: 0 enable, 1 rx_irq_en, 2 frame_irq_en; read back as written.
REQ-020 SHALL implement states IDLE and SHIFT: IDLE->SHIFT on synced SS falling edge while enable=1; SHIFT->IDLE on synced SS rising edge or enable=0.
REQ-021 On IDLE->SHIFT: bit counter := 0; TX shifter := TX hold and tx_empty := 1; if tx_empty was already 1, shifter := 8'hFF and tx_underrun := 1.
REQ-022 In SHIFT: leading SCK edge (falling if POLARITY=1) samples MOSI into the RX shifter MSB-first and increments the 3-bit counter, wrapping at 8.
REQ-023 On the leading edge completing bit 7: the byte goes to RX storage with rx_valid := 1, 3 clk cycles after the pin edge; if storage is full, the byte is dropped, old data is kept, and rx_overrun := 1.
REQ-024 On the trailing edge: if the counter is 0, reload the TX shifter per REQ-021; otherwise shift left.
REQ-025 spi_miso SHALL equal TX shifter bit 7; spi_miso_oe = enable & state==SHIFT.
REQ-026 SHALL discard a partial byte on SS rise mid-byte, set frame_end := 1 and return to IDLE.
REQ-027 If a TX reload and a CPU DATA write occur in the same cycle: the reload uses the old hold value, then the hold takes the write and tx_empty := 0.
REQ-028 If a CPU pop and an RX byte store occur in the same cycle: the pop is applied first, the new byte is stored, and no overrun results.
REQ-029 interrupt = (rx_valid & rx_irq_en) | (frame_end & frame_irq_en).

Reset
REQ-030 SHALL, while resetq=0, asynchronously force: state IDLE, counters 0, shifters 8'hFF, RX storage empty, TX hold 0 with tx_empty=1, all sticky flags 0, CONTROL 0, spi_miso_oe=0, interrupt=0.
REQ-031 SHALL resynchronise without leaving SHIFT if reset is released while SS is low; SHIFT requires a fresh SS falling edge.

Configuration
REQ-032 SHALL honour macro SPI_TARGET_FIFO_EN: when defined, RX storage is a 4-entry FIFO, rx_valid = not empty, overrun = push when full, and STATUS[8:6] = entry count 0-4.
REQ-033 SHALL, without SPI_TARGET_FIFO_EN, use a single-byte RX holding register with STATUS[8:6] reading 0.

Verification
REQ-034 Bench SHALL cover: enable=1, TX hold=0xA5, host sends 0x3C -> host receives 0xA5, DATA reads 0x3C, rx_valid then 0 after pop.
REQ-035 Bench SHALL cover: TX empty, host clocks 1 byte -> MISO shows 0xFF and tx_underrun=1; writing 0x08 to STATUS clears it.
REQ-036 Bench SHALL cover: host sends 0x11, 0x22 without pop, no FIFO -> DATA=0x11 and rx_overrun=1; with FIFO -> count=2, pops give 0x11 then 0x22.
REQ-037 Bench SHALL cover: SS raised after 5 bits with frame_irq_en=1 -> no rx_valid, frame_end=1, interrupt=1.
REQ-038 Bench SHALL cover: resetq pulsed low mid-byte -> outputs match REQ-030 immediately, and the next full frame with SS re-asserted transfers correctly.
REQ-039 Bench SHALL cover: POLARITY=0 instance, host sends 0x81 -> DATA reads 0x81.
